// File: rtl/gate_nor_arbiter_if.sv
// Request/grant and result handshake bundle for the shared NOR arbiter.
// The master side is the client group and the result consumer; the slave side is the arbiter.
interface gate_nor_arbiter_if #(
  parameter int N = 4,
  parameter int R = 4
);
  localparam int IDW = (R > 2) ? $clog2(R) : 1;

  logic [R-1:0]   req;
  logic [R*N-1:0] a_in;
  logic [R*N-1:0] b_in;
  logic [R-1:0]   gnt;
  logic [N-1:0]   f_out;
  logic [IDW-1:0] f_id;
  logic           f_valid;
  logic           f_ready;
  logic           busy;

  modport master (
    output req, a_in, b_in, f_ready,
    input  gnt, f_out, f_id, f_valid, busy
  );

  modport slave (
    input  req, a_in, b_in, f_ready,
    output gnt, f_out, f_id, f_valid, busy
  );
endinterface

// File: rtl/gate_nor_arbiter.sv
// Round-robin arbiter in front of one registered N-bit NOR unit shared by R requesters.
// state | meaning
// IDLE  | waiting for any req; captures the round-robin winner's operands
// CALC  | one cycle: computes ~(A|B) into the result register
// HOLD  | result valid, held until the consumer raises f_ready
module gate_nor_arbiter #(
  parameter int N = 4,
  parameter int R = 4
) (
  input  logic                clk,
  input  logic                rst,
  gate_nor_arbiter_if.slave   bus
);
  localparam int IDW = (R > 2) ? $clog2(R) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [R-1:0]   gnt_q, gnt_d;
  logic [N-1:0]   op_a_q, op_a_d;
  logic [N-1:0]   op_b_q, op_b_d;
  logic [N-1:0]   f_out_q, f_out_d;
  logic [IDW-1:0] f_id_q, f_id_d;
  logic           f_valid_q, f_valid_d;

  logic           found;
  logic [IDW-1:0] win;
  logic [IDW:0]   cand;
  logic [IDW:0]   nxt;

  // Circular search starting at ptr; the extra bit keeps ptr+k from overflowing before the wrap.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < R; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(R)) cand = cand - (IDW+1)'(R);
      if (!found && bus.req[cand[IDW-1:0]]) begin
        found = 1'b1;
        win   = cand[IDW-1:0];
      end
    end
    nxt = {1'b0, win} + (IDW+1)'(1);
    if (nxt >= (IDW+1)'(R)) nxt = '0;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = '0;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    f_out_d   = f_out_q;
    f_id_d    = f_id_q;
    f_valid_d = f_valid_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          op_a_d  = bus.a_in[win*N +: N];
          op_b_d  = bus.b_in[win*N +: N];
          gnt_d   = R'(1) << win;
          f_id_d  = win;
          ptr_d   = nxt[IDW-1:0];
          state_d = CALC;
        end
      end
      CALC: begin
        f_out_d   = ~(op_a_q | op_b_q);
        f_valid_d = 1'b1;
        state_d   = HOLD;
      end
      HOLD: begin
        if (bus.f_ready) begin
          f_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        f_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      f_out_q   <= '0;
      f_id_q    <= '0;
      f_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      f_out_q   <= f_out_d;
      f_id_q    <= f_id_d;
      f_valid_q <= f_valid_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.f_out   = f_out_q;
  assign bus.f_id    = f_id_q;
  assign bus.f_valid = f_valid_q;
  assign bus.busy    = (state_q != IDLE);
endmodule

// File: tb/tb_gate_nor_arbiter.sv
// Directed and randomized checks of gate_nor_arbiter against a transaction-level reference:
// round-robin winner picked by modular search, result = ~(A|B) of the winner's slice.
module tb_gate_nor_arbiter;
  localparam int N = 4;
  localparam int R = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   m_ptr  = 0;
  logic [N-1:0] last_f;
  int   last_id;

  always #5 clk = ~clk;

  gate_nor_arbiter_if #(.N(N), .R(R)) bus ();
  gate_nor_arbiter #(.N(N), .R(R)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input int ptr, input logic [R-1:0] rq);
    for (int k = 0; k < R; k++) begin
      if (rq[(ptr + k) % R]) return (ptr + k) % R;
    end
    return -1;
  endfunction

  // One full transaction: capture, CALC, optional backpressure, release to IDLE.
  task automatic op(input logic [R-1:0] rq, input logic [R*N-1:0] a, input logic [R*N-1:0] b,
                    input int hold, input logic [R-1:0] rq_after);
    int w;
    logic [N-1:0] ef;
    w  = rr_pick(m_ptr, rq);
    ef = ~(a[w*N +: N] | b[w*N +: N]);
    bus.req     = rq;
    bus.a_in    = a;
    bus.b_in    = b;
    bus.f_ready = 1'($urandom_range(0, 1));
    tick();
    chk("gnt_onehot", 32'(bus.gnt), 32'(1 << w));
    chk("busy_calc", 32'(bus.busy), 32'd1);
    chk("fvalid_calc", 32'(bus.f_valid), 32'd0);
    m_ptr    = (w + 1) % R;
    bus.req  = rq_after;
    bus.a_in = 32'($urandom);
    bus.b_in = 32'($urandom);
    tick();
    chk("gnt_drop", 32'(bus.gnt), 32'd0);
    chk("fvalid", 32'(bus.f_valid), 32'd1);
    chk("f_out", 32'(bus.f_out), 32'(ef));
    chk("f_id", 32'(bus.f_id), 32'(w));
    bus.f_ready = (hold == 0);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", 32'(bus.f_valid), 32'd1);
      chk("hold_f_out", 32'(bus.f_out), 32'(ef));
      chk("hold_f_id", 32'(bus.f_id), 32'(w));
      chk("hold_busy", 32'(bus.busy), 32'd1);
      chk("hold_gnt", 32'(bus.gnt), 32'd0);
    end
    bus.f_ready = 1'b1;
    tick();
    chk("rel_valid", 32'(bus.f_valid), 32'd0);
    chk("rel_busy", 32'(bus.busy), 32'd0);
    chk("rel_gnt", 32'(bus.gnt), 32'd0);
    chk("rel_f_out_kept", 32'(bus.f_out), 32'(ef));
    chk("rel_f_id_kept", 32'(bus.f_id), 32'(w));
    last_f  = ef;
    last_id = w;
  endtask

  initial begin
    rst         = 1'b1;
    bus.req     = 4'b1111;
    bus.a_in    = 16'h1234;
    bus.b_in    = 16'h0000;
    bus.f_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_valid", 32'(bus.f_valid), 32'd0);
      chk("rst_f_out", 32'(bus.f_out), 32'd0);
      chk("rst_f_id", 32'(bus.f_id), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
    end
    rst = 1'b0;

    // Round robin with all requests held: 0,1,2,3,0, results all zero.
    op(4'b1111, 16'hCCC0, 16'hFFFF, 0, 4'b1111);
    for (int i = 0; i < 4; i++) op(4'b1111, 16'hCCC0, 16'hFFFF, 0, 4'b1111);

    // Idle with no request.
    bus.req = '0;
    tick();
    chk("idle_gnt", 32'(bus.gnt), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // Single request from requester 2.
    op(4'b0100, 16'h0A00, 16'h0000, 0, 4'b0000);
    // Pointer skip: grant 1, then req 0011 wraps to 0, then 1.
    op(4'b0010, 16'h00F0, 16'h0000, 0, 4'b0000);
    op(4'b0011, 16'h0003, 16'h0005, 0, 4'b0000);
    op(4'b0011, 16'h0050, 16'h0030, 0, 4'b0000);
    // Backpressure with requester 3 waiting.
    op(4'b0001, 16'h0009, 16'h0002, 5, 4'b1000);
    op(4'b1000, 16'h6000, 16'h0000, 0, 4'b0000);

    // Reset while a result is held.
    bus.req     = 4'b0001;
    bus.a_in    = 16'h0001;
    bus.b_in    = 16'h0000;
    bus.f_ready = 1'b0;
    tick();
    chk("mid_gnt", 32'(bus.gnt), 32'd1);
    bus.req = '0;
    tick();
    tick();
    chk("mid_hold_valid", 32'(bus.f_valid), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(bus.f_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_gnt", 32'(bus.gnt), 32'd0);
    chk("mid_rst_f_out", 32'(bus.f_out), 32'd0);
    rst   = 1'b0;
    m_ptr = 0;
    op(4'b1111, 16'h1111, 16'h2222, 0, 4'b0000);
    op(4'b0001, 16'h000F, 16'h0000, 1, 4'b0000);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      logic [R-1:0] rq;
      rq = 4'($urandom_range(1, 15));
      op(rq, 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
